clk_burst_arb: RTL

Round-robin scheduler that shares the free-running simulation/system clock among NREQ requesters by issuing gated clock-enable bursts.
- Each requester asks for a burst of N enable cycles.
- The arbiter grants one requester at a time, drives clk_en high for exactly N cycles, then enforces a guard gap before the next grant.
- Sits directly downstream of clk_gen; its clk_en and active_id feed clock-gated test blocks.

---
 rtl/clk_burst_arb.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/clk_burst_arb.sv
// Round-robin clock-enable burst scheduler: grants one requester at a time a burst
// of len clk_en cycles followed by a guard gap. Optional stats: CLK_BURST_ARB_STATS_EN.
module clk_burst_arb #(
  parameter int NREQ      = 4,
  parameter int LEN_W     = 8,
  parameter int GUARD_CYC = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  // req is a level held until its one-cycle gnt pulse; it is only looked at while
  // idle, so a req dropped before gnt is simply withdrawn. len is captured at grant.
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*LEN_W-1:0]     len,
  output logic [NREQ-1:0]           gnt,
  output logic [NREQ-1:0]           done,
  output logic                      clk_en,
  output logic [$clog2(NREQ)-1:0]   active_id,
  output logic                      busy,
`ifdef CLK_BURST_ARB_STATS_EN
  output logic [31:0]               enable_cnt,
  output logic [15:0]               burst_cnt,
`endif
  output logic [1:0]                o_dbg_state
);

  localparam int IDW = $clog2(NREQ);
  localparam int GW  = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
  localparam logic [GW-1:0] GUARD_INIT = GW'((GUARD_CYC > 0) ? GUARD_CYC - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_RUN   = 2'd2,
    S_GUARD = 2'd3
  } state_t;

  state_t             r_state;
  logic [IDW-1:0]     r_rr;
  logic [IDW-1:0]     r_owner;
  logic [LEN_W-1:0]   r_cnt;
  logic [GW-1:0]      r_guard;
  logic [NREQ-1:0]    r_gnt;
  logic [NREQ-1:0]    r_done;
  logic               r_clk_en;
  logic               r_busy;

  state_t             w_state_n;
  logic [IDW-1:0]     w_rr_n;
  logic [IDW-1:0]     w_owner_n;
  logic [LEN_W-1:0]   w_cnt_n;
  logic [GW-1:0]      w_guard_n;
  logic [NREQ-1:0]    w_gnt_n;
  logic [NREQ-1:0]    w_done_n;
  logic               w_clk_en_n;
  logic               w_busy_n;

  logic               w_win_vld;
  logic [IDW-1:0]     w_win_id;
  logic [IDW-1:0]     w_idx;
  logic [IDW-1:0]     w_rr_inc;
  logic [LEN_W-1:0]   w_win_len;
  logic [NREQ-1:0]    w_win_onehot;
  logic [NREQ-1:0]    w_owner_onehot;

  // First requester at or above the rr pointer, wrapping past NREQ-1.
  always_comb begin
    w_win_vld = 1'b0;
    w_win_id  = '0;
    w_idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = IDW'((int'(r_rr) + k) % NREQ);
      if (!w_win_vld && req[w_idx]) begin
        w_win_vld = 1'b1;
        w_win_id  = w_idx;
      end
    end
  end

  assign w_rr_inc       = IDW'((int'(w_win_id) + 1) % NREQ);
  assign w_win_len      = len[int'(w_win_id)*LEN_W +: LEN_W];
  assign w_win_onehot   = NREQ'(1) << w_win_id;
  assign w_owner_onehot = NREQ'(1) << r_owner;

  always_comb begin
    w_state_n  = r_state;
    w_rr_n     = r_rr;
    w_owner_n  = r_owner;
    w_cnt_n    = r_cnt;
    w_guard_n  = r_guard;
    w_gnt_n    = '0;
    w_done_n   = '0;
    w_clk_en_n = 1'b0;
    w_busy_n   = r_busy;
    case (r_state)
      S_IDLE: begin
        if (w_win_vld) begin
          w_state_n = S_GRANT;
          w_gnt_n   = w_win_onehot;
          w_busy_n  = 1'b1;
          w_owner_n = w_win_id;
          w_cnt_n   = w_win_len;
          w_rr_n    = w_rr_inc;
        end
      end
      S_GRANT: begin
        // A zero-length burst still spends one RUN cycle, carrying done with clk_en low.
        w_state_n = S_RUN;
        if (r_cnt != '0) begin
          w_clk_en_n = 1'b1;
          w_cnt_n    = r_cnt - LEN_W'(1);
        end
        if (r_cnt <= LEN_W'(1)) w_done_n = w_owner_onehot;
      end
      S_RUN: begin
        if (r_cnt != '0) begin
          w_clk_en_n = 1'b1;
          w_cnt_n    = r_cnt - LEN_W'(1);
          if (r_cnt == LEN_W'(1)) w_done_n = w_owner_onehot;
        end else if (GUARD_CYC > 0) begin
          w_state_n = S_GUARD;
          w_guard_n = GUARD_INIT;
        end else begin
          w_state_n = S_IDLE;
          w_busy_n  = 1'b0;
        end
      end
      S_GUARD: begin
        if (r_guard != '0) begin
          w_guard_n = r_guard - GW'(1);
        end else begin
          w_state_n = S_IDLE;
          w_busy_n  = 1'b0;
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_rr     <= '0;
      r_owner  <= '0;
      r_cnt    <= '0;
      r_guard  <= '0;
      r_gnt    <= '0;
      r_done   <= '0;
      r_clk_en <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_rr     <= w_rr_n;
      r_owner  <= w_owner_n;
      r_cnt    <= w_cnt_n;
      r_guard  <= w_guard_n;
      r_gnt    <= w_gnt_n;
      r_done   <= w_done_n;
      r_clk_en <= w_clk_en_n;
      r_busy   <= w_busy_n;
    end
  end

  assign gnt         = r_gnt;
  assign done        = r_done;
  assign clk_en      = r_clk_en;
  assign active_id   = r_owner;
  assign busy        = r_busy;
  assign o_dbg_state = r_state;

`ifdef CLK_BURST_ARB_STATS_EN
  logic [31:0] r_enable_cnt;
  logic [15:0] r_burst_cnt;

  // Counters advance with the same next-cycle values that load clk_en/done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_enable_cnt <= '0;
      r_burst_cnt  <= '0;
    end else begin
      if (w_clk_en_n && (r_enable_cnt != 32'hFFFF_FFFF)) r_enable_cnt <= r_enable_cnt + 32'd1;
      if (|w_done_n) r_burst_cnt <= r_burst_cnt + 16'd1;
    end
  end

  assign enable_cnt = r_enable_cnt;
  assign burst_cnt  = r_burst_cnt;
`else
  // Statistics counters are not built.
`endif

endmodule
